srambank_param: RTL and testbench
=================================

# srambank_param

Parametrised synchronous single-port SRAM bank, the generalised successor of the fixed 256x18 bank used in the generated SRAM macros. Adds configurable depth and width, per-bit write mask, a read-valid strobe, a sticky read/write-conflict flag, out-of-range address handling and an optional output pipeline stage. It sits below the bank-select decode of a multi-bank SRAM array; one instance per bank.

## Interface
- WORDS, 256, number of words; need not be a power of two; must be at least 2.
- WIDTH, 18, data word width in bits; must be at least 1.
- AW, 8, address width; must satisfy 2^AW >= WORDS.

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ADDRESS  in  AW  word address
- wd  in  WIDTH  write data
- wmask  in  WIDTH  per-bit write enable; 1 = write that bit
- banksel  in  1  access enable; read and write are ignored when low
- read  in  1  read enable
- write  in  1  write enable
- dataout  out  WIDTH  read data, held until the next accepted read
- dvalid  out  1  one-cycle strobe marking new dataout
- rw_err  out  1  sticky conflict/range error flag

## Operation
- Accepted write: banksel & write & (ADDRESS < WORDS).
  - mem[ADDRESS][i] <= wd[i] for every bit i where wmask[i]=1.
  - Other bits keep their value.
- Accepted read: banksel & read & !write.
  - Write has priority over read, as in the fixed bank.
  - In-range address: capture mem[ADDRESS]. This is the pre-write content, because no write happens in the same cycle.
  - Address >= WORDS: capture all zeros.
- On every accepted read, dataout updates and dvalid pulses high for exactly one cycle.
- With no accepted read, dataout holds its value and dvalid is 0. Writes never alter dataout, even to the address last read.
- rw_err is set to 1, and stays 1 until reset, by either of:
  - banksel & read & write in the same cycle;
  - banksel & (read | write) with ADDRESS >= WORDS.
- Out-of-range write: memory is unchanged.
- Memory contents are not reset. A read of a never-written word returns X in simulation.
- Reset mid-operation (rst_n low): dataout, dvalid, the pipeline stage and rw_err clear immediately. An access in flight is discarded. Memory writes are blocked while rst_n is low.

## Timing
- Reset values: dataout = 0, dvalid = 0, rw_err = 0. The internal pipeline register is 0 with its valid bit 0.
- Without SRAMBANK_OUTREG_EN, read latency is 1: read accepted at edge N, so dataout and dvalid are valid after edge N.
- With SRAMBANK_OUTREG_EN, read latency is 2: dataout and dvalid are valid after edge N+1.
- Write then read of the same address on the next cycle returns the newly written data.
- Back-to-back reads on consecutive cycles:
  - dvalid stays high on consecutive cycles;
  - one result per cycle;
  - results appear in issue order.
- rw_err rises on the edge that samples the offending request.

## Configuration
- SRAMBANK_OUTREG_EN defined:
  - An extra register stage sits between the array read and dataout/dvalid.
  - dvalid is delayed together with the data.
  - Read latency is 2. The intended use is timing closure on large WORDS.
- SRAMBANK_OUTREG_EN undefined:
  - Single-stage output.
  - Read latency is 1, behaviour otherwise identical.
- Write behaviour and rw_err timing are the same in both builds.

## Test plan
- Reset:
  - Stimulus: hold rst_n low for 3 cycles, then release.
  - Response: dataout = 0, dvalid = 0, rw_err = 0. An access issued while rst_n is low leaves memory and all outputs unchanged.
- Masked write:
  - Stimulus: write 0x3FFFF to address 5, then write 0x00000 with wmask = 0x000FF, then read address 5.
  - Response: dataout = 0x3FF00 and dvalid pulses once, after 1 edge (2 edges with SRAMBANK_OUTREG_EN).
- Conflict:
  - Stimulus: banksel = read = write = 1, address 7, wd = 0x12345.
  - Response: mem[7] = 0x12345, dataout unchanged, dvalid = 0, rw_err = 1 and stays 1.
- Out of range (WORDS = 200):
  - Stimulus: write then read address 210.
  - Response: no memory change, dataout = 0, dvalid pulses, rw_err = 1.
- Streaming:
  - Stimulus: read addresses 0, 1, 2, 3 on consecutive cycles after writing 0xA, 0xB, 0xC, 0xD there.
  - Response: dvalid high for 4 consecutive cycles with dataout 0xA, 0xB, 0xC, 0xD in order. Afterwards dataout holds 0xD and dvalid returns to 0.
- Reset mid-read:
  - Stimulus: assert rst_n low for one cycle between accepting a read and its output.
  - Response: dataout = 0, dvalid never pulses for that read.

Source files
------------

// File: rtl/srambank_param.sv
// ---------------------------------------------------------------------------
// srambank_param
//   Parametrised synchronous single-port SRAM bank, one instance per bank
//   below the bank-select decode of a multi-bank array.
//
//   Build option: SRAMBANK_OUTREG_EN
//     defined   -> extra output register stage, read latency 2
//     undefined -> single output stage, read latency 1
//
//   Parameters
//     WORDS  number of words (>= 2, need not be a power of two)
//     WIDTH  data word width (>= 1)
//     AW     address width (2**AW >= WORDS)
//
//   Ports
//     clk      clock, rising edge
//     rst_n    asynchronous active-low reset
//     ADDRESS  word address
//     wd       write data
//     wmask    per-bit write enable (1 = write that bit)
//     banksel  access enable
//     read     read enable
//     write    write enable (priority over read)
//     dataout  read data, held until the next accepted read
//     dvalid   one-cycle strobe marking new dataout
//     rw_err   sticky read/write-conflict or out-of-range flag
// ---------------------------------------------------------------------------
module srambank_param #(
  parameter int WORDS = 256,
  parameter int WIDTH = 18,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ADDRESS,
  input  logic [WIDTH-1:0] wd,
  input  logic [WIDTH-1:0] wmask,
  input  logic             banksel,
  input  logic             read,
  input  logic             write,
  output logic [WIDTH-1:0] dataout,
  output logic             dvalid,
  output logic             rw_err
);

  localparam logic [AW:0] WORDS_C = (AW+1)'(WORDS);

  logic [WIDTH-1:0] mem_q [WORDS];

  logic             in_range;
  logic             wr_acc;
  logic             rd_acc;
  logic             err_set;

  logic [WIDTH-1:0] data_p0_d, data_p0_q;
  logic             vld_p0_d,  vld_p0_q;
  logic             err_d,     err_q;

  // Extra bit on the compare so WORDS == 2**AW works without overflow.
  assign in_range = ({1'b0, ADDRESS} < WORDS_C);
  assign wr_acc   = banksel & write & in_range;
  // Write wins over read: a simultaneous request is a write plus an error.
  assign rd_acc   = banksel & read & ~write;
  assign err_set  = banksel & ((read & write) | ((read | write) & ~in_range));

  // Array: not reset; writes suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem_q[ADDRESS] <= (mem_q[ADDRESS] & ~wmask) | (wd & wmask);
    end
  end

  always_comb begin
    vld_p0_d  = rd_acc;
    data_p0_d = data_p0_q;
    if (rd_acc) begin
      data_p0_d = in_range ? mem_q[ADDRESS] : '0;
    end
    err_d = err_q | err_set;
  end

  // Stage p0: array read result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0_q <= '0;
      vld_p0_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      data_p0_q <= data_p0_d;
      vld_p0_q  <= vld_p0_d;
      err_q     <= err_d;
    end
  end

  assign rw_err = err_q;

`ifdef SRAMBANK_OUTREG_EN
  logic [WIDTH-1:0] data_p1_d, data_p1_q;
  logic             vld_p1_d,  vld_p1_q;

  // p1 only loads on a valid p0 result so dataout holds between reads.
  always_comb begin
    vld_p1_d  = vld_p0_q;
    data_p1_d = vld_p0_q ? data_p0_q : data_p1_q;
  end

  // Stage p1: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1_q <= '0;
      vld_p1_q  <= 1'b0;
    end else begin
      data_p1_q <= data_p1_d;
      vld_p1_q  <= vld_p1_d;
    end
  end

  assign dataout = data_p1_q;
  assign dvalid  = vld_p1_q;
`else
  assign dataout = data_p0_q;
  assign dvalid  = vld_p0_q;
`endif

endmodule

// File: tb/tb_srambank_param.sv
`timescale 1ns/1ps
module tb_srambank_param;

  localparam int WORDS = 200;
  localparam int WIDTH = 18;
  localparam int AW    = 8;
`ifdef SRAMBANK_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [AW-1:0]    ADDRESS = '0;
  logic [WIDTH-1:0] wd = '0;
  logic [WIDTH-1:0] wmask = '0;
  logic             banksel = 1'b0;
  logic             read = 1'b0;
  logic             write = 1'b0;
  logic [WIDTH-1:0] dataout;
  logic             dvalid;
  logic             rw_err;

  always #5 clk = ~clk;

  srambank_param #(.WORDS(WORDS), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ADDRESS(ADDRESS), .wd(wd), .wmask(wmask),
    .banksel(banksel), .read(read), .write(write),
    .dataout(dataout), .dvalid(dvalid), .rw_err(rw_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic r, input logic w, input int a,
                       input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
    banksel = b; read = r; write = w; ADDRESS = AW'(a); wd = d; wmask = m;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 0, '0, '0);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed { logic v; logic [WIDTH-1:0] d; } res_t;
  logic [WIDTH-1:0] m_mem [WORDS];
  res_t             m_pipe [$];
  logic [WIDTH-1:0] m_do;
  logic             m_dv;
  logic             m_err;

  task automatic mdl_reset();
    m_pipe.delete();
    for (int i = 0; i < LAT-1; i++) m_pipe.push_back('0);
    m_do = '0; m_dv = 1'b0; m_err = 1'b0;
  endtask

  // One clock of the bank, rst_n assumed high.
  task automatic mdl_step(input logic b, input logic r, input logic w, input int a,
                          input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
    res_t e, f;
    e.v = b && r && !w;
    e.d = (e.v && a < WORDS) ? m_mem[a] : '0;
    if (b && w && a < WORDS) m_mem[a] = (m_mem[a] & ~m) | (d & m);
    if (b && ((r && w) || ((r || w) && a >= WORDS))) m_err = 1'b1;
    m_pipe.push_back(e);
    f = m_pipe.pop_front();
    m_dv = f.v;
    if (f.v) m_do = f.d;
  endtask

  task automatic rcycle(input logic b, input logic r, input logic w, input int a,
                        input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
    drive(b, r, w, a, d, m);
    mdl_step(b, r, w, a, d, m);
    tick();
    chk("rnd_dataout", dataout, m_do);
    chk("rnd_dvalid", dvalid, m_dv);
    chk("rnd_rw_err", rw_err, m_err);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic b, r, w;
    logic [AW-1:0] a;
    logic [WIDTH-1:0] d, m;
    logic [WIDTH-1:0] edo;
    logic edv, eerr;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic exp_v;
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'd5,   18'h3FFFF, 18'h3FFFF, 18'h00000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'd5,   18'h00000, 18'h000FF, 18'h00000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'd5,   18'h00000, 18'h00000, 18'h3FF00, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'd0,   18'h0000A, 18'h3FFFF, 18'h3FF00, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'd1,   18'h0000B, 18'h3FFFF, 18'h3FF00, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'd2,   18'h0000C, 18'h3FFFF, 18'h3FF00, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'd3,   18'h0000D, 18'h3FFFF, 18'h3FF00, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'd5,   18'h00000, 18'h3FFFF, 18'h3FF00, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'd0,   18'h00000, 18'h00000, 18'h0000A, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'd5,   18'h00000, 18'h00000, 18'h00000, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'd1,   18'h00000, 18'h00000, 18'h00000, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 8'd1,   18'h3FFFF, 18'h3FFFF, 18'h00000, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 8'd1,   18'h00000, 18'h00000, 18'h0000B, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 8'd7,   18'h12345, 18'h3FFFF, 18'h0000B, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 8'd7,   18'h00000, 18'h00000, 18'h12345, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 8'd210, 18'h00000, 18'h00000, 18'h00000, 1'b1, 1'b1};

    // Reset held for 3 cycles
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_dataout", dataout, 0);
    chk("reset_dvalid", dvalid, 0);
    chk("reset_rw_err", rw_err, 0);
    rst_n = 1'b1;
    tick();

    // Table: each vector's effect is sampled LAT edges after it is issued
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].b, tbl[i].r, tbl[i].w, int'(tbl[i].a), tbl[i].d, tbl[i].m);
      tick();
      if (LAT == 2) begin
        idle();
        tick();
      end
      chk($sformatf("tbl%0d_dataout", i), dataout, tbl[i].edo);
      chk($sformatf("tbl%0d_dvalid", i), dvalid, tbl[i].edv);
      chk($sformatf("tbl%0d_rw_err", i), rw_err, tbl[i].eerr);
      idle();
    end

    // Access during reset is ignored and blocks the write
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1, 18'h3FFFF, 18'h3FFFF);
    repeat (3) tick();
    chk("rstacc_dataout", dataout, 0);
    chk("rstacc_dvalid", dvalid, 0);
    chk("rstacc_rw_err", rw_err, 0);
    idle();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 1'b1, 1'b0, 1, '0, '0);
    tick();
    idle();
    if (LAT == 2) tick();
    chk("rstacc_mem1", dataout, 18'h0000B);
    chk("rstacc_dv", dvalid, 1);

    // Streaming reads 0..3
    for (int k = 0; k < LAT + 4; k++) begin
      if (k < 4) drive(1'b1, 1'b1, 1'b0, k, '0, '0);
      else idle();
      tick();
      exp_v = (k >= LAT-1) && (k <= LAT+2);
      chk($sformatf("stream%0d_dvalid", k), dvalid, exp_v);
      if (exp_v) chk($sformatf("stream%0d_dataout", k), dataout, 18'hA + (k - (LAT-1)));
    end
    idle();
    tick();
    chk("stream_hold_dataout", dataout, 18'h0000D);
    chk("stream_hold_dvalid", dvalid, 0);
    chk("stream_err_clear", rw_err, 0);

    // Out of range with a fresh error flag
    drive(1'b1, 1'b0, 1'b1, 210, 18'h3FFFF, 18'h3FFFF);
    tick();
    chk("oor_wr_err_edge", rw_err, 1);
    drive(1'b1, 1'b1, 1'b0, 210, '0, '0);
    tick();
    idle();
    if (LAT == 2) tick();
    chk("oor_rd_dataout", dataout, 0);
    chk("oor_rd_dvalid", dvalid, 1);
    drive(1'b1, 1'b1, 1'b0, 2, '0, '0);
    tick();
    idle();
    if (LAT == 2) tick();
    chk("oor_mem2_intact", dataout, 18'h0000C);
    chk("oor_err_sticky", rw_err, 1);

    // Reset between accepting a read and its output
    drive(1'b1, 1'b1, 1'b0, 3, '0, '0);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_dataout", dataout, 0);
    chk("midrst_dvalid", dvalid, 0);
    chk("midrst_rw_err", rw_err, 0);
    tick();
    chk("midrst_dvalid_2", dvalid, 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_dvalid_3", dvalid, 0);
    chk("midrst_dataout_3", dataout, 0);

    // Randomised run against the reference model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mdl_reset();
    for (int a = 0; a < WORDS; a++) begin
      rcycle(1'b1, 1'b0, 1'b1, a, WIDTH'($urandom), '1);
    end
    for (int n = 0; n < 600; n++) begin
      int op, a;
      a = ($urandom_range(0, 19) == 0) ? int'($urandom_range(WORDS, 255)) : int'($urandom_range(0, WORDS-1));
      op = int'($urandom_range(0, 19));
      if (n == 300) begin
        // Mid-run reset with a write attempt that must be blocked
        drive(1'b1, 1'b0, 1'b1, a, WIDTH'($urandom), '1);
        rst_n = 1'b0;
        mdl_reset();
        #1;
        chk("rnd_rst_dataout", dataout, 0);
        chk("rnd_rst_dvalid", dvalid, 0);
        tick();
        rst_n = 1'b1;
        idle();
      end else if (op < 3) begin
        rcycle(1'b0, 1'($urandom), 1'($urandom), a, WIDTH'($urandom), WIDTH'($urandom));
      end else if (op < 11) begin
        rcycle(1'b1, 1'b1, 1'b0, a, WIDTH'($urandom), WIDTH'($urandom));
      end else if (op < 19) begin
        rcycle(1'b1, 1'b0, 1'b1, a, WIDTH'($urandom), WIDTH'($urandom));
      end else begin
        rcycle(1'b1, 1'b1, 1'b1, a, WIDTH'($urandom), WIDTH'($urandom));
      end
    end
    for (int k = 0; k < LAT + 1; k++) rcycle(1'b0, 1'b0, 1'b0, 0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
